// File: rtl/reg_writeback_queue.sv
// Writeback queue between the ALU / load-store producers and the banked
// register file; drains up to two same-bank, distinct-address writes per cycle.
module reg_writeback_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int BANK_W = 6
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         aluValid_i,
  output logic                         aluReady_o,
  input  logic [ADDR_W-1:0]            aluAddr_i,
  input  logic [DATA_W-1:0]            aluData_i,
  input  logic [BANK_W-1:0]            aluBank_i,
  input  logic                         lsValid_i,
  output logic                         lsReady_o,
  input  logic [ADDR_W-1:0]            lsAddr_i,
  input  logic [DATA_W-1:0]            lsData_i,
  input  logic [BANK_W-1:0]            lsBank_i,
  output logic                         wrAEn_o,
  output logic                         wrBEn_o,
  output logic [ADDR_W-1:0]            wrAAddr_o,
  output logic [ADDR_W-1:0]            wrBAddr_o,
  output logic [DATA_W-1:0]            wrAData_o,
  output logic [DATA_W-1:0]            wrBData_o,
  output logic [BANK_W-1:0]            bank_o,
  input  logic [ADDR_W-1:0]            qryAddr_i,
  input  logic [BANK_W-1:0]            qryBank_i,
  output logic                         qryHit_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [BANK_W-1:0] bank_q [DEPTH];

  logic [PW-1:0] head, tail;
  logic [PW-1:0] head_n1, tail_n1, ls_slot;
  logic [CW-1:0] count, free;
  logic          alu_acc, ls_acc;
  logic          pop_h, pop_n;
  logic [1:0]    n_enq, n_pop;

  assign free    = CW'(DEPTH) - count;
  assign head_n1 = head + PW'(1);
  assign tail_n1 = tail + PW'(1);

  assign aluReady_o = !reset_i && (free != '0);
  assign lsReady_o  = !reset_i &&
                      ((free >= CW'(2)) ||
                       ((free != '0) && !aluValid_i));

  assign alu_acc = aluValid_i && aluReady_o;
  assign ls_acc  = lsValid_i && lsReady_o;
  assign ls_slot = alu_acc ? tail_n1 : tail;
  assign n_enq   = {1'b0, alu_acc} + {1'b0, ls_acc};

  // Second pop only when it cannot reorder writes to one register
  assign pop_h = (count != '0);
  assign pop_n = (count >= CW'(2)) &&
                 (bank_q[head_n1] == bank_q[head]) &&
                 (addr_q[head_n1] != addr_q[head]);
  assign n_pop = {1'b0, pop_h} + {1'b0, pop_n};

  always_ff @(posedge clock_i) begin
    if (alu_acc) begin
      addr_q[tail] <= aluAddr_i;
      data_q[tail] <= aluData_i;
      bank_q[tail] <= aluBank_i;
    end
    if (ls_acc) begin
      addr_q[ls_slot] <= lsAddr_i;
      data_q[ls_slot] <= lsData_i;
      bank_q[ls_slot] <= lsBank_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      wrAEn_o   <= 1'b0;
      wrBEn_o   <= 1'b0;
      wrAAddr_o <= '0;
      wrBAddr_o <= '0;
      wrAData_o <= '0;
      wrBData_o <= '0;
      bank_o    <= '0;
    end else begin
      count     <= count + CW'(n_enq) - CW'(n_pop);
      head      <= head + PW'(n_pop);
      tail      <= tail + PW'(n_enq);
      wrAEn_o   <= pop_h;
      wrAAddr_o <= pop_h ? addr_q[head] : '0;
      wrAData_o <= pop_h ? data_q[head] : '0;
      bank_o    <= pop_h ? bank_q[head] : '0;
      wrBEn_o   <= pop_n;
      wrBAddr_o <= pop_n ? addr_q[head_n1] : '0;
      wrBData_o <= pop_n ? data_q[head_n1] : '0;
    end
  end

  logic [PW-1:0] off;
  logic          hit;

  always_comb begin
    off = '0;
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head;
      if ((CW'(off) < count) &&
          (addr_q[i] == qryAddr_i) &&
          (bank_q[i] == qryBank_i))
        hit = 1'b1;
    end
    if (wrAEn_o && wrAAddr_o == qryAddr_i &&
        bank_o == qryBank_i)
      hit = 1'b1;
    if (wrBEn_o && wrBAddr_o == qryAddr_i &&
        bank_o == qryBank_i)
      hit = 1'b1;
  end

  assign qryHit_o = hit;
  assign count_o  = count;
  assign empty_o  = (count == '0) && !wrAEn_o && !wrBEn_o;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench for reg_writeback_queue: a queue-based reference model
// predicts writes; a negedge monitor compares them as the DUT emits them.
module tb_reg_writeback_queue;

  localparam int DEPTH = 8;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int BW = 6;
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] bank;
  } ent_t;

  typedef struct packed {
    logic          a_en;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          b_en;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic [BW-1:0] bank;
  } rec_t;

  logic          clk = 1'b0;
  logic          reset_i = 1'b0;
  logic          aluValid_i = 1'b0, lsValid_i = 1'b0;
  logic          aluReady_o, lsReady_o;
  logic [AW-1:0] aluAddr_i = '0, lsAddr_i = '0, qryAddr_i = '0;
  logic [DW-1:0] aluData_i = '0, lsData_i = '0;
  logic [BW-1:0] aluBank_i = '0, lsBank_i = '0, qryBank_i = '0;
  logic          wrAEn_o, wrBEn_o, qryHit_o, empty_o;
  logic [AW-1:0] wrAAddr_o, wrBAddr_o;
  logic [DW-1:0] wrAData_o, wrBData_o;
  logic [BW-1:0] bank_o;
  logic [CW-1:0] count_o;

  always #5 clk = ~clk;

  reg_writeback_queue #(
    .DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .BANK_W(BW)
  ) dut (
    .clock_i(clk), .reset_i(reset_i),
    .aluValid_i(aluValid_i), .aluReady_o(aluReady_o),
    .aluAddr_i(aluAddr_i), .aluData_i(aluData_i),
    .aluBank_i(aluBank_i),
    .lsValid_i(lsValid_i), .lsReady_o(lsReady_o),
    .lsAddr_i(lsAddr_i), .lsData_i(lsData_i),
    .lsBank_i(lsBank_i),
    .wrAEn_o(wrAEn_o), .wrBEn_o(wrBEn_o),
    .wrAAddr_o(wrAAddr_o), .wrBAddr_o(wrBAddr_o),
    .wrAData_o(wrAData_o), .wrBData_o(wrBData_o),
    .bank_o(bank_o),
    .qryAddr_i(qryAddr_i), .qryBank_i(qryBank_i),
    .qryHit_o(qryHit_o), .count_o(count_o),
    .empty_o(empty_o)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_on = 1'b0;
  ent_t q[$];
  rec_t exp_q[$];
  rec_t last = '0;
  rec_t mon_e;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic ent_t mk(input int a, input int d, input int b);
    ent_t e;
    e.addr = AW'(a);
    e.data = DW'(d);
    e.bank = BW'(b);
    return e;
  endfunction

  function automatic ent_t rnd();
    return mk($urandom_range(0, 3), int'($urandom),
              $urandom_range(0, 1));
  endfunction

  // Reference model: arrival-ordered list, drained by the bank/address rule
  task automatic model_edge();
    int   fr;
    bit   ar, lr;
    ent_t h, n;
    rec_t r;
    if (reset_i) begin
      q.delete();
      last = '0;
      return;
    end
    fr = DEPTH - q.size();
    ar = fr >= 1;
    lr = (fr >= 2) || (fr >= 1 && !aluValid_i);
    r = '0;
    if (q.size() > 0) begin
      h = q.pop_front();
      r.a_en = 1'b1;
      r.a_addr = h.addr;
      r.a_data = h.data;
      r.bank = h.bank;
      if (q.size() > 0 && q[0].bank == h.bank &&
          q[0].addr != h.addr) begin
        n = q.pop_front();
        r.b_en = 1'b1;
        r.b_addr = n.addr;
        r.b_data = n.data;
      end
    end
    last = r;
    if (r.a_en) exp_q.push_back(r);
    if (aluValid_i && ar)
      q.push_back(mk(aluAddr_i, aluData_i, aluBank_i));
    if (lsValid_i && lr)
      q.push_back(mk(lsAddr_i, lsData_i, lsBank_i));
  endtask

  task automatic step();
    int fr;
    bit hit;
    if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
      ent_t e;
      e = q[$urandom_range(0, q.size() - 1)];
      qryAddr_i = e.addr;
      qryBank_i = e.bank;
    end else if (last.a_en && $urandom_range(0, 2) == 0) begin
      qryAddr_i = last.b_en ? last.b_addr : last.a_addr;
      qryBank_i = last.bank;
    end else begin
      qryAddr_i = AW'($urandom_range(0, 7));
      qryBank_i = BW'($urandom_range(0, 2));
    end
    #1;
    fr = DEPTH - q.size();
    chk("aluReady", 32'(aluReady_o),
        32'(!reset_i && fr >= 1));
    chk("lsReady", 32'(lsReady_o),
        32'(!reset_i && (fr >= 2 || (fr >= 1 && !aluValid_i))));
    chk("count", 32'(count_o), 32'(q.size()));
    chk("empty", 32'(empty_o),
        32'(q.size() == 0 && !last.a_en && !last.b_en));
    hit = 1'b0;
    foreach (q[i])
      if (q[i].addr == qryAddr_i && q[i].bank == qryBank_i)
        hit = 1'b1;
    if (last.a_en && last.a_addr == qryAddr_i &&
        last.bank == qryBank_i) hit = 1'b1;
    if (last.b_en && last.b_addr == qryAddr_i &&
        last.bank == qryBank_i) hit = 1'b1;
    chk("qryHit", 32'(qryHit_o), 32'(hit));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input bit rst,
                       input bit av, input ent_t a,
                       input bit lv, input ent_t l);
    reset_i    = rst;
    aluValid_i = av;
    aluAddr_i  = a.addr;
    aluData_i  = a.data;
    aluBank_i  = a.bank;
    lsValid_i  = lv;
    lsAddr_i   = l.addr;
    lsData_i   = l.data;
    lsBank_i   = l.bank;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, 0, '0);
  endtask

  always @(negedge clk) begin
    if (mon_on && (wrAEn_o !== 1'b0 || wrBEn_o !== 1'b0 ||
                   exp_q.size() > 0)) begin
      mon_e = '0;
      if (exp_q.size() > 0) mon_e = exp_q.pop_front();
      chk("wrAEn", 32'(wrAEn_o), 32'(mon_e.a_en));
      chk("wrAAddr", 32'(wrAAddr_o), 32'(mon_e.a_addr));
      chk("wrAData", 32'(wrAData_o), 32'(mon_e.a_data));
      chk("wrBEn", 32'(wrBEn_o), 32'(mon_e.b_en));
      chk("wrBAddr", 32'(wrBAddr_o), 32'(mon_e.b_addr));
      chk("wrBData", 32'(wrBData_o), 32'(mon_e.b_data));
      chk("bank", 32'(bank_o), 32'(mon_e.bank));
    end
  end

  initial begin
    @(negedge clk);
    drive(1, 0, '0, 0, '0);
    drive(1, 1, mk(1, 1, 0), 1, mk(2, 2, 0));
    mon_on = 1'b1;
    idle(2);

    drive(0, 1, mk(3, 16'h1234, 0), 0, '0);
    idle(4);

    drive(0, 1, mk(5, 16'hAAAA, 0), 1, mk(5, 16'hBBBB, 0));
    idle(4);

    drive(0, 1, mk(2, 16'h0202, 1), 1, mk(4, 16'h0404, 2));
    idle(4);

    for (int i = 0; i < 6; i++)
      drive(0, 1, mk(2 * i, 100 + i, 3),
               1, mk(2 * i + 1, 200 + i, 3));
    idle(6);

    for (int i = 0; i < 12; i++)
      drive(0, 1, mk(i, 300 + i, 0), 1, mk(i, 400 + i, 1));
    idle(10);

    for (int i = 0; i < 12; i++)
      drive(0, 1, mk(7, 500 + i, 0), 1, mk(7, 600 + i, 0));
    for (int i = 0; i < 4; i++)
      drive(0, 1, mk(i, 700 + i, 0), 0, '0);
    idle(10);

    for (int i = 0; i < 3; i++)
      drive(0, 1, mk(i, 800 + i, 0), 1, mk(i, 900 + i, 1));
    drive(1, 1, mk(9, 16'hDEAD, 0), 1, mk(10, 16'hBEEF, 0));
    idle(4);

    for (int i = 0; i < 500; i++)
      drive($urandom_range(0, 59) == 0,
            $urandom_range(0, 3) != 0, rnd(),
            $urandom_range(0, 3) != 0, rnd());
    idle(12);

    chk("drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
